// File: rtl/grf_hazard_tracker.sv
// grf_hazard_tracker: in-flight GRF writer tracking for E/M/W, D-stage
// stall and D/E forwarding selects. Optional macro: FORWARD_EN.
module grf_hazard_tracker (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic       RsUseD,
  input  logic       RtUseD,
  input  logic [1:0] RsTuseD,
  input  logic [1:0] RtTuseD,
  input  logic [4:0] A3D,
  input  logic       RFWrD,
  input  logic [1:0] TnewD,
  output logic       Stall,
  output logic [1:0] FwdRsD,
  output logic [1:0] FwdRtD,
  output logic [1:0] FwdRsE,
  output logic [1:0] FwdRtE
);

  typedef struct packed {
    logic       v;
    logic [4:0] a3;
    logic [1:0] tnew;
  } ent_t;

  typedef struct packed {
    logic       rd;
    logic [4:0] a;
  } src_t;

  localparam logic [1:0] SelNone = 2'b00;
  localparam logic [1:0] SelNear = 2'b01;
  localparam logic [1:0] SelFar  = 2'b10;

  ent_t e_q, e_d;
  ent_t m_q, m_d;
  ent_t w_q, w_d;
  src_t rs_e_q, rs_e_d;
  src_t rt_e_q, rt_e_d;

  function automatic logic hit(
    input ent_t       x,
    input logic       u,
    input logic [4:0] s
  );
    return u && (s != 5'd0) && x.v && (x.a3 == s);
  endfunction

  function automatic logic [1:0] sat_dec(
    input logic [1:0] x
  );
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

  logic rs_hit_e, rs_hit_m;
  logic rt_hit_e, rt_hit_m;
  logic capture_v;

  assign rs_hit_e  = hit(e_q, RsUseD, RsD);
  assign rs_hit_m  = hit(m_q, RsUseD, RsD);
  assign rt_hit_e  = hit(e_q, RtUseD, RtD);
  assign rt_hit_m  = hit(m_q, RtUseD, RtD);
  assign capture_v = RFWrD && (A3D != 5'd0);

`ifdef FORWARD_EN

  logic rse_hit_m, rse_hit_w;
  logic rte_hit_m, rte_hit_w;
  logic rs_stall, rt_stall;
  logic [1:0] unused_wtnew;

  assign rse_hit_m = hit(m_q, rs_e_q.rd, rs_e_q.a);
  assign rse_hit_w = hit(w_q, rs_e_q.rd, rs_e_q.a);
  assign rte_hit_m = hit(m_q, rt_e_q.rd, rt_e_q.a);
  assign rte_hit_w = hit(w_q, rt_e_q.rd, rt_e_q.a);
  assign unused_wtnew = w_q.tnew;

  function automatic logic late(
    input logic       he,
    input logic       hm,
    input logic [1:0] te,
    input logic [1:0] tm,
    input logic [1:0] tuse
  );
    logic r;
    r = 1'b0;
    if (he) begin
      r = te > tuse;
    end else if (hm) begin
      r = tm > tuse;
    end
    return r;
  endfunction

  function automatic logic [1:0] sel_d(
    input logic       he,
    input logic       hm,
    input logic [1:0] te,
    input logic [1:0] tm
  );
    logic [1:0] r;
    r = SelNone;
    if (he) begin
      if (te == 2'd0) r = SelNear;
    end else if (hm) begin
      if (tm == 2'd0) r = SelFar;
    end
    return r;
  endfunction

  function automatic logic [1:0] sel_e(
    input logic       hm,
    input logic       hw,
    input logic [1:0] tm
  );
    logic [1:0] r;
    r = SelNone;
    if (hm) begin
      if (tm == 2'd0) r = SelNear;
    end else if (hw) begin
      r = SelFar;
    end
    return r;
  endfunction

  // Stall when the youngest matching writer is not ready by time of use
  always_comb begin
    rs_stall = late(rs_hit_e, rs_hit_m,
                    e_q.tnew, m_q.tnew, RsTuseD);
    rt_stall = late(rt_hit_e, rt_hit_m,
                    e_q.tnew, m_q.tnew, RtTuseD);
    Stall    = rs_stall | rt_stall;
  end

  // D-stage selects from E/M; W is covered by the GRF bypass
  always_comb begin
    FwdRsD = sel_d(rs_hit_e, rs_hit_m, e_q.tnew, m_q.tnew);
    FwdRtD = sel_d(rt_hit_e, rt_hit_m, e_q.tnew, m_q.tnew);
  end

  // E-stage selects search M then W
  always_comb begin
    FwdRsE = sel_e(rse_hit_m, rse_hit_w, m_q.tnew);
    FwdRtE = sel_e(rte_hit_m, rte_hit_w, m_q.tnew);
  end

`else

  logic [1:0]  unused_tuse;
  logic [11:0] unused_src;
  logic [9:0]  unused_ent;

  assign unused_tuse = RsTuseD ^ RtTuseD;
  assign unused_src  = {rs_e_q, rt_e_q};
  assign unused_ent  = {m_q.tnew, w_q};

  // Without forwarding any E/M producer blocks the reader
  always_comb begin
    Stall  = rs_hit_e | rs_hit_m | rt_hit_e | rt_hit_m;
    FwdRsD = SelNone;
    FwdRtD = SelNone;
    FwdRsE = SelNone;
    FwdRtE = SelNone;
  end

`endif

  // Advance writers down the pipe; a stall bubbles E
  always_comb begin
    w_d      = m_q;
    w_d.tnew = 2'd0;
    m_d      = e_q;
    m_d.tnew = sat_dec(e_q.tnew);
    e_d      = '0;
    rs_e_d   = '0;
    rt_e_d   = '0;
    if (!Stall) begin
      e_d.v    = capture_v;
      e_d.a3   = A3D;
      e_d.tnew = TnewD;
      rs_e_d   = '{rd: RsUseD, a: RsD};
      rt_e_d   = '{rd: RtUseD, a: RtD};
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      rs_e_q <= '0;
      rt_e_q <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
      rs_e_q <= rs_e_d;
      rt_e_q <= rt_e_d;
    end
  end

endmodule

// File: tb/tb_grf_hazard_tracker.sv
// tb_grf_hazard_tracker: scoreboard bench with an in-flight
// instruction model; honours FORWARD_EN like the design.
module tb_grf_hazard_tracker;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] RsD, RtD, A3D;
  logic       RsUseD, RtUseD, RFWrD;
  logic [1:0] RsTuseD, RtTuseD, TnewD;
  logic       Stall;
  logic [1:0] FwdRsD, FwdRtD, FwdRsE, FwdRtE;

  always #5 Clk = ~Clk;

  grf_hazard_tracker dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .RsD     (RsD),
    .RtD     (RtD),
    .RsUseD  (RsUseD),
    .RtUseD  (RtUseD),
    .RsTuseD (RsTuseD),
    .RtTuseD (RtTuseD),
    .A3D     (A3D),
    .RFWrD   (RFWrD),
    .TnewD   (TnewD),
    .Stall   (Stall),
    .FwdRsD  (FwdRsD),
    .FwdRtD  (FwdRtD),
    .FwdRsE  (FwdRsE),
    .FwdRtE  (FwdRtE)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic       rsu;
    logic [1:0] rstu;
    logic [4:0] rt;
    logic       rtu;
    logic [1:0] rttu;
    logic [4:0] a3;
    logic       wr;
    logic [1:0] tn;
  } din_t;

  typedef struct packed {
    logic       st;
    logic [1:0] frd;
    logic [1:0] ftd;
    logic [1:0] fre;
    logic [1:0] fte;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Model: instruction occupying stage k (0=E,1=M,2=W), its destination
  // and the absolute cycle its result becomes available.
  bit mwr[3];
  int mdst[3];
  int mrdy[3];
  int cyc = 0;
  bit esu, etu;
  int esr, etr;

  function automatic din_t mk(
    input logic rst, input logic [4:0] rs, input logic rsu,
    input logic [1:0] rstu, input logic [4:0] rt, input logic rtu,
    input logic [1:0] rttu, input logic [4:0] a3, input logic wr,
    input logic [1:0] tn);
    din_t d;
    d = '{rst: rst, rs: rs, rsu: rsu, rstu: rstu, rt: rt, rtu: rtu,
          rttu: rttu, a3: a3, wr: wr, tn: tn};
    return d;
  endfunction

  function automatic void find(input int s, input bit u, input int from,
                               output int stg, output int rem);
    stg = -1;
    rem = 0;
    for (int k = from; k < 3; k++) begin
      if (stg < 0 && u && s != 0 && mwr[k] && mdst[k] == s) begin
        stg = k;
        if (k == 2 || mrdy[k] <= cyc) rem = 0;
        else rem = mrdy[k] - cyc;
      end
    end
  endfunction

  function automatic logic [1:0] dsel(input int stg, input int rem);
    if (stg == 0 && rem == 0) return 2'b01;
    if (stg == 1 && rem == 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] esel(input int stg, input int rem);
    if (stg == 1 && rem == 0) return 2'b01;
    if (stg == 2) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step(input din_t d, output bit stl);
    exp_t e;
    int sg, sr, tg, tr, eg, er;
    bit ss, ts;
    Reset = d.rst; RsD = d.rs; RsUseD = d.rsu; RsTuseD = d.rstu;
    RtD = d.rt; RtUseD = d.rtu; RtTuseD = d.rttu;
    A3D = d.a3; RFWrD = d.wr; TnewD = d.tn;
    find(int'(d.rs), d.rsu, 0, sg, sr);
    find(int'(d.rt), d.rtu, 0, tg, tr);
`ifdef FORWARD_EN
    ss = sg >= 0 && sr > int'(d.rstu);
    ts = tg >= 0 && tr > int'(d.rttu);
    e.frd = dsel(sg, sr);
    e.ftd = dsel(tg, tr);
    find(esr, esu, 1, eg, er);
    e.fre = esel(eg, er);
    find(etr, etu, 1, eg, er);
    e.fte = esel(eg, er);
`else
    ss = sg == 0 || sg == 1;
    ts = tg == 0 || tg == 1;
    e.frd = 2'b00;
    e.ftd = 2'b00;
    e.fre = 2'b00;
    e.fte = 2'b00;
`endif
    e.st = ss | ts;
    stl  = e.st;
    sbq.push_back(e);
    @(posedge Clk);
    cyc++;
    if (d.rst) begin
      for (int k = 0; k < 3; k++) mwr[k] = 1'b0;
      esu = 1'b0;
      etu = 1'b0;
    end else begin
      for (int k = 2; k > 0; k--) begin
        mwr[k]  = mwr[k-1];
        mdst[k] = mdst[k-1];
        mrdy[k] = mrdy[k-1];
      end
      mwr[0]  = !stl && d.wr && d.a3 != 5'd0;
      mdst[0] = int'(d.a3);
      mrdy[0] = cyc + int'(d.tn);
      esu = !stl && d.rsu;
      etu = !stl && d.rtu;
      esr = int'(d.rs);
      etr = int'(d.rt);
    end
    #1;
  endtask

  // Re-issue the same D instruction while it is held by a stall
  task automatic issue(input din_t d);
    bit s;
    for (int i = 0; i < 4; i++) begin
      step(d, s);
      if (!s) break;
    end
  endtask

  task automatic nops(input int n);
    bit s;
    for (int i = 0; i < n; i++) step(mk(0,0,0,0,0,0,0,0,0,0), s);
  endtask

  task automatic chk(input string n, input logic [1:0] act,
                     input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%b want=%b", n, $time, act, exp);
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("Stall", {1'b0, Stall}, {1'b0, e.st});
        chk("FwdRsD", FwdRsD, e.frd);
        chk("FwdRtD", FwdRtD, e.ftd);
        chk("FwdRsE", FwdRsE, e.fre);
        chk("FwdRtE", FwdRtE, e.fte);
      end
    end
  end

  initial begin
    din_t d;
    bit   s;
    bit   last_st;
    for (int k = 0; k < 3; k++) begin
      mwr[k] = 1'b0; mdst[k] = 0; mrdy[k] = 0;
    end
    esu = 1'b0; etu = 1'b0; esr = 0; etr = 0;
    Reset = 1'b1; RsD = '0; RtD = '0; A3D = '0;
    RsUseD = 1'b0; RtUseD = 1'b0; RFWrD = 1'b0;
    RsTuseD = '0; RtTuseD = '0; TnewD = '0;
    @(posedge Clk);
    #1;

    nops(1);
    // full pipe of $5 writers, then reset, then read $5
    for (int i = 0; i < 3; i++) issue(mk(0,0,0,0,0,0,0,5,1,2));
    step(mk(1,5,1,1,0,0,0,0,0,0), s);
    step(mk(0,5,1,1,5,1,0,0,0,0), s);
    nops(3);
    // lw $8 then add using $8
    issue(mk(0,0,0,0,0,0,0,8,1,2));
    issue(mk(0,8,1,1,0,0,0,10,1,1));
    nops(3);
    // load then branch (two-cycle stall with forwarding)
    issue(mk(0,0,0,0,0,0,0,8,1,2));
    issue(mk(0,8,1,0,0,0,0,0,0,0));
    nops(3);
    // addu $9 then beq on $9
    issue(mk(0,0,0,0,0,0,0,9,1,1));
    issue(mk(0,9,1,0,0,0,0,0,0,0));
    nops(3);
    // jal $31 then jr $31
    issue(mk(0,0,0,0,0,0,0,31,1,0));
    issue(mk(0,31,1,0,0,0,0,0,0,0));
    nops(3);
    // writer to $0 then reader of $0
    issue(mk(0,0,0,0,0,0,0,0,1,1));
    issue(mk(0,0,1,0,0,1,0,0,0,0));
    nops(3);
    // two $4 writers, youngest one wins
    issue(mk(0,0,0,0,0,0,0,4,1,2));
    issue(mk(0,0,0,0,0,0,0,4,1,0));
    issue(mk(0,4,1,0,4,1,1,0,0,0));
    nops(3);
    // addu $3 then sw reading $3 as store data
    issue(mk(0,0,0,0,0,0,0,3,1,1));
    issue(mk(0,29,1,1,3,1,2,0,0,0));
    nops(3);
    // reset asserted mid-stall
    issue(mk(0,0,0,0,0,0,0,7,1,2));
    step(mk(0,7,1,0,0,0,0,0,0,0), s);
    step(mk(1,7,1,0,0,0,0,0,0,0), s);
    step(mk(0,7,1,0,0,0,0,0,0,0), s);
    nops(3);

    // randomized stream, usually holding D while stalled
    last_st = 1'b0;
    d = mk(0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 1500; i++) begin
      if (!(last_st && $urandom_range(0, 9) < 8)) begin
        d.rst  = ($urandom_range(0, 59) == 0);
        d.rs   = 5'($urandom_range(0, 7));
        d.rsu  = 1'($urandom_range(0, 1));
        d.rstu = 2'($urandom_range(0, 3));
        d.rt   = 5'($urandom_range(0, 7));
        d.rtu  = 1'($urandom_range(0, 1));
        d.rttu = 2'($urandom_range(0, 3));
        d.a3   = 5'($urandom_range(0, 7));
        d.wr   = ($urandom_range(0, 3) != 0);
        d.tn   = 2'($urandom_range(0, 3));
      end else begin
        d.rst = 1'b0;
      end
      step(d, s);
      last_st = s;
    end
    nops(2);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge Clk);
    #1;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d want=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
